// File: rtl/log_adder.sv
// log_adder: log-domain adder stage of a Mitchell-style approximate 8x8 multiplier
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   in_valid,a,b: operands, captured when in_valid is high
//   out_valid   : registered copy of in_valid
//   frac_*      : fraction-adder sum, carry-out and bit-5-to-6 carry
//   char_result, lod_cout : characteristic sum and its carry-out
//   zero_flag   : an operand was zero; all results are then forced to 0
module log_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    output logic       frac_cout,
    output logic       lod_cout,
    output logic       frac_carry,
    output logic [6:0] frac_result,
    output logic [2:0] char_result,
    output logic       zero_flag
);
    logic [2:0] ka, kb;
    logic [6:0] xa, xb;
    logic [7:0] s;
    logic [6:0] s_lo;
    logic [3:0] c;
    logic       zero;
    always_comb begin
        ka = 3'd0;
        kb = 3'd0;
        for (int i = 0; i < 8; i++) begin
            ka = a[i] ? 3'(i) : ka;
            kb = b[i] ? 3'(i) : kb;
        end
        // shifting the leading one out of bit 7 leaves the left-aligned fraction
        xa   = 7'(a << (3'd7 - ka));
        xb   = 7'(b << (3'd7 - kb));
        s    = {1'b0, xa} + {1'b0, xb};
        s_lo = {1'b0, xa[5:0]} + {1'b0, xb[5:0]};
        c    = {1'b0, ka} + {1'b0, kb} + {3'd0, s[7]};
        zero = (a == 8'd0) || (b == 8'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            frac_cout   <= 1'b0;
            lod_cout    <= 1'b0;
            frac_carry  <= 1'b0;
            frac_result <= 7'd0;
            char_result <= 3'd0;
            zero_flag   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                frac_cout   <= zero ? 1'b0 : s[7];
                lod_cout    <= zero ? 1'b0 : c[3];
                frac_carry  <= zero ? 1'b0 : s_lo[6];
                frac_result <= zero ? 7'd0 : s[6:0];
                char_result <= zero ? 3'd0 : c[2:0];
                zero_flag   <= zero;
            end
        end
    end
endmodule

// File: tb/tb_log_adder.sv
// tb_log_adder: scoreboard bench for log_adder with hand-computed directed vectors
module tb_log_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'h6A;
    logic [7:0] b = 8'h16;
    logic       out_valid, frac_cout, lod_cout, frac_carry, zero_flag;
    logic [6:0] frac_result;
    logic [2:0] char_result;
    int         passed = 0;
    int         total = 0;
    // packed result: {zero_flag, lod_cout, frac_carry, frac_cout, char_result, frac_result}
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;
    logic [13:0] got;

    log_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .frac_cout(frac_cout), .lod_cout(lod_cout),
        .frac_carry(frac_carry), .frac_result(frac_result),
        .char_result(char_result), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    assign got = {zero_flag, lod_cout, frac_carry, frac_cout, char_result, frac_result};

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: every valid output is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) check("unexpected_output", {1'b1, got}, 15'd0);
            else check("result", {1'b1, got}, {1'b1, exp_q.pop_front()});
        end
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [13:0] e;
    } vec_t;

    function automatic logic [13:0] pk(input logic z, input logic lc, input logic fc,
                                       input logic fo, input logic [2:0] ch, input logic [6:0] fr);
        return {z, lc, fc, fo, ch, fr};
    endfunction

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h6A, 8'h16, pk(0, 1, 1, 1, 3'd3, 7'h04)});
        vecs.push_back('{8'h80, 8'h40, pk(0, 1, 0, 0, 3'd5, 7'h00)});
        vecs.push_back('{8'h01, 8'h01, pk(0, 0, 0, 0, 3'd0, 7'h00)});
        vecs.push_back('{8'h00, 8'h55, pk(1, 0, 0, 0, 3'd0, 7'h00)});
        vecs.push_back('{8'h55, 8'h00, pk(1, 0, 0, 0, 3'd0, 7'h00)});
        vecs.push_back('{8'h03, 8'h03, pk(0, 0, 0, 1, 3'd3, 7'h00)});
        vecs.push_back('{8'h02, 8'h01, pk(0, 0, 0, 0, 3'd1, 7'h00)});
        vecs.push_back('{8'h10, 8'h20, pk(0, 1, 0, 0, 3'd1, 7'h00)});
        vecs.push_back('{8'h18, 8'h0C, pk(0, 1, 0, 1, 3'd0, 7'h00)});
        vecs.push_back('{8'hFF, 8'hFF, pk(0, 1, 1, 1, 3'd7, 7'h7E)});

        repeat (3) @(negedge clk);
        check("reset_outputs", {out_valid, got}, 15'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {out_valid, got}, 15'd0);

        foreach (vecs[i]) begin
            a = vecs[i].a;
            b = vecs[i].b;
            in_valid = 1'b1;
            exp_q.push_back(vecs[i].e);
            last_exp = vecs[i].e;
            @(negedge clk);
        end
        in_valid = 1'b0;
        a = 8'h6A;
        b = 8'h16;
        @(negedge clk);
        check("hold_valid_low", {14'd0, out_valid}, 15'd0);
        check("hold_results", {1'b0, got}, {1'b0, last_exp});
        @(negedge clk);
        check("hold_second_cycle", {out_valid, got}, {1'b0, last_exp});

        // capture one more, then reset asynchronously mid-cycle
        a = 8'hFF;
        b = 8'hFF;
        in_valid = 1'b1;
        exp_q.push_back(pk(0, 1, 1, 1, 3'd7, 7'h7E));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_clear", {out_valid, got}, 15'd0);
        @(negedge clk);
        check("reset_held_valid", {out_valid, got}, 15'd0);
        check("queue_drained", {11'd0, 4'(exp_q.size())}, 15'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_idle", {out_valid, got}, 15'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
